// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO with a valid/ack pop port.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx_fifo #(
    parameter int sym_cnt    = 13333,
    parameter int SCW        = 14,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_serial,
    output logic [7:0]            rd_dat,
    output logic                  rd_valid,
    input  logic                  rd_ack,
    output logic                  rx_busy,
    output logic                  frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  overflow,
    input  logic                  clr_err,
    output logic [DEPTH_LOG2:0]   fill
);
    localparam logic [SCW-1:0] HALF = SCW'(sym_cnt / 2);
    // Counting down through 0 makes a reload of sym_cnt-1 give a period of exactly sym_cnt clocks
    localparam logic [SCW-1:0] RELOAD = SCW'(sym_cnt - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state, state_n;
    logic [SCW-1:0] cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     sh, sh_n;
    logic           rx_s1, rxs;
    logic           tick, push_req, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic           par_bad, par_bad_n, perr_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_s1     <= rx_serial;
            rxs       <= rx_s1;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_n;
            parity_err <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        sh_n     = sh;
        push_req = 1'b0;
        ferr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        tick  = cnt == '0;
        cnt_n = (state == IDLE) ? cnt : tick ? RELOAD : cnt - SCW'(1);
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = HALF;
                end
            end
            START: begin
                idx_n = '0;
                if (tick) state_n = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    sh_n  = {rxs, sh[7:1]};
                    idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx == 3'd7) state_n = PARITY;
`else
                    if (idx == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bad_n = rxs ^ (^sh);
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    ferr_n  = !rxs;
`ifdef UART_RX_PARITY_EN
                    push_req = rxs && !par_bad;
                    perr_n   = rxs && par_bad;
`else
                    push_req = rxs;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_busy = state != IDLE;

    logic [7:0]          mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                full, pop, push;

    assign rd_valid = wr_ptr != rd_ptr;
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop      = rd_ack && rd_valid;
    assign push     = push_req && (!full || pop);
    assign rd_dat   = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign fill     = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + (DEPTH_LOG2+1)'(push);
            rd_ptr   <= rd_ptr + (DEPTH_LOG2+1)'(pop);
            overflow <= (push_req && !push) || (overflow && !clr_err);
        end
    end
endmodule
